// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage data-cache request, stall and load-extension controller
module mem_stage_ctrl #(
    parameter int unsigned DONE_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        mem_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_address_q, dmem_address_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_byte_enable_q, dmem_byte_enable_d;
    logic [31:0] load_data_q, load_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  done_cnt_q, done_cnt_d;

    logic        op;
    logic        is_rd;
    logic        legal;
    logic [3:0]  mask_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_c;

    // Decode the incoming request: read beats write, legality depends on width, alignment and direction
    always_comb begin
        op      = valid_in & (mem_read_in | mem_write_in);
        is_rd   = mem_read_in;
        legal   = 1'b0;
        mask_c  = 4'b0000;
        wdata_c = 32'h0;
        case (funct3_in)
            3'b000:  legal = 1'b1;
            3'b100:  legal = is_rd;
            3'b001:  legal = ~addr_in[0];
            3'b101:  legal = is_rd & ~addr_in[0];
            3'b010:  legal = (addr_in[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
        if (!is_rd) begin
            case (funct3_in[1:0])
                2'b00: begin
                    mask_c  = 4'b0001 << addr_in[1:0];
                    wdata_c = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    mask_c  = 4'b0011 << addr_in[1:0];
                    wdata_c = {2{wdata_in[15:0]}};
                end
                default: begin
                    mask_c  = 4'b1111;
                    wdata_c = wdata_in;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (addr_lo_q)
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            2'd3: byte_sel = dmem_rdata[31:24];
            default: byte_sel = dmem_rdata[7:0];
        endcase
        half_sel = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_c = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_c = {24'h0, byte_sel};
            3'b001:  ext_c = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_c = {16'h0, half_sel};
            default: ext_c = dmem_rdata;
        endcase
    end

    // Next-state and registered-output computation for the IDLE/BUSY/DONE sequence
    always_comb begin
        state_d            = state_q;
        dmem_read_d        = dmem_read_q;
        dmem_write_d       = dmem_write_q;
        dmem_address_d     = dmem_address_q;
        dmem_wdata_d       = dmem_wdata_q;
        dmem_byte_enable_d = dmem_byte_enable_q;
        load_data_d        = load_data_q;
        funct3_d           = funct3_q;
        addr_lo_d          = addr_lo_q;
        done_cnt_d         = done_cnt_q;
        case (state_q)
            IDLE: begin
                load_data_d = 32'h0;
                if (op && legal) begin
                    state_d            = BUSY;
                    dmem_read_d        = is_rd;
                    dmem_write_d       = ~is_rd;
                    dmem_address_d     = {addr_in[31:2], 2'b00};
                    dmem_byte_enable_d = mask_c;
                    dmem_wdata_d       = wdata_c;
                    funct3_d           = funct3_in;
                    addr_lo_d          = addr_in[1:0];
                end
            end
            BUSY: begin
                if (dmem_resp) begin
                    state_d            = DONE;
                    dmem_read_d        = 1'b0;
                    dmem_write_d       = 1'b0;
                    dmem_address_d     = 32'h0;
                    dmem_byte_enable_d = 4'b0000;
                    dmem_wdata_d       = 32'h0;
                    load_data_d        = dmem_read_q ? ext_c : 32'h0;
                    done_cnt_d         = 8'h0;
                end
            end
            DONE: begin
                // valid_in still shows the finished instruction here, so it is deliberately not looked at
                if (done_cnt_q == 8'(DONE_HOLD - 1)) begin
                    state_d     = IDLE;
                    load_data_d = 32'h0;
                end else begin
                    done_cnt_d = done_cnt_q + 8'h1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides any in-flight request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            dmem_read_q        <= 1'b0;
            dmem_write_q       <= 1'b0;
            dmem_address_q     <= 32'h0;
            dmem_wdata_q       <= 32'h0;
            dmem_byte_enable_q <= 4'b0000;
            load_data_q        <= 32'h0;
            funct3_q           <= 3'b000;
            addr_lo_q          <= 2'b00;
            done_cnt_q         <= 8'h0;
        end else begin
            state_q            <= state_d;
            dmem_read_q        <= dmem_read_d;
            dmem_write_q       <= dmem_write_d;
            dmem_address_q     <= dmem_address_d;
            dmem_wdata_q       <= dmem_wdata_d;
            dmem_byte_enable_q <= dmem_byte_enable_d;
            load_data_q        <= load_data_d;
            funct3_q           <= funct3_d;
            addr_lo_q          <= addr_lo_d;
            done_cnt_q         <= done_cnt_d;
        end
    end

    // Stall must rise in the acceptance cycle itself, so it and the error pulse are combinational
    assign stall            = ~rst & (((state_q == IDLE) & op & legal) | (state_q == BUSY));
    assign mem_error        = ~rst & (state_q == IDLE) & op & ~legal;
    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = dmem_byte_enable_q;
    assign load_data        = load_data_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the decoded control word: turns dmem_read/dmem_write, funct3, ALU address and rs2 data into a data-cache request, and holds the pipeline until the cache responds.
- Generates word-aligned address, byte mask and lane-shifted store data.
- Returns sign/zero-extended load data to the WB mux.
- Sits between the EX/MEM pipeline register and the data cache port.

Parameters:
- DONE_HOLD, 1, cycles the result is presented with stall deasserted before returning to IDLE (fixed at 1; exposed for bench visibility only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX/MEM register holds a live instruction
- mem_read_in  in  1  dmem_read from control word
- mem_write_in  in  1  dmem_write from control word
- funct3_in  in  3  load/store width and sign
- addr_in  in  32  ALU result (effective address)
- wdata_in  in  32  rs2_out
- dmem_resp  in  1  cache response, single-cycle pulse
- dmem_rdata  in  32  cache read word
- dmem_read  out  1  cache read strobe
- dmem_write  out  1  cache write strobe
- dmem_address  out  32  {addr[31:2],2'b00}
- dmem_wdata  out  32  store data shifted to lane
- dmem_byte_enable  out  4  byte mask
- load_data  out  32  extended load result
- stall  out  1  freeze IF/ID/EX/MEM registers
- mem_error  out  1  misaligned or illegal funct3 pulse

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE. All outputs 0: dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, load_data, stall, mem_error.
- Request detection: op = valid_in & (mem_read_in | mem_write_in). If both read and write are set, the read wins and the write is ignored.
- Alignment legality:
  - Byte (funct3 000/100) is always legal.
  - Half (001/101) needs addr[0]=0.
  - Word (010) needs addr[1:0]=00.
  - funct3 011/110/111 is illegal.
  - Stores accept only 000/001/010.
- IDLE, op legal:
  - Same cycle: stall=1 combinationally.
  - Clock edge: latch addr, funct3, mask, wdata and rd/wr into request registers; go to BUSY.
  - Strobes rise the cycle after acceptance (registered outputs).
- IDLE, op illegal: no request, stall=0, mem_error=1 that cycle only, load_data=0.
- IDLE, no op: stall=0, outputs hold 0.
- BUSY:
  - Strobe, address, mask and wdata are held constant; stall=1.
  - On dmem_resp=1: drop the strobe at the next edge, register load_data from dmem_rdata, go to DONE.
  - Wait is unbounded.
- DONE:
  - stall=0 and load_data valid for exactly 1 cycle; the pipeline advances on this edge.
  - valid_in is ignored here, so the same instruction is never reissued.
  - Next state IDLE.
- Minimum latency with a resp in the first BUSY cycle: acceptance to DONE = 2 cycles; stall high for 2 cycles.
- Byte mask:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Mask is 0 for reads.
- Store data: byte = wdata[7:0] replicated ×4; half = wdata[15:0] replicated ×2; word = wdata.
- Load extraction:
  - Byte: select lane addr[1:0].
  - Half: select lane addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - Stores leave load_data = 0.
- dmem_resp in IDLE or DONE (stale) is ignored.
- rst asserted in BUSY: next cycle IDLE, strobes 0, stall 0; the outstanding resp is ignored.
- rst wins over every other event.

Test Plan:
- lw addr 0x1004, resp after 3 BUSY cycles, rdata 0xDEADBEEF:
  - address 0x1004, mask 0000, dmem_read held 3 cycles.
  - load_data 0xDEADBEEF in DONE; stall 1 for 4 cycles.
- lb addr 0x2003, rdata 0x80FF_0000 → load_data 0xFFFFFF80; lbu same → 0x00000080.
- sh addr 0x3002, wdata 0x1234ABCD → dmem_write, address 0x3000, wdata 0xABCDABCD, mask 1100, load_data 0.
- lw addr 0x1001 → mem_error pulse 1 cycle, dmem_read never asserted, stall 0.
- sb 0x4001 immediately followed by lw 0x4000 → two separate transactions; the second is accepted only after DONE; no duplicate write.
- rst in the 2nd BUSY cycle, then stale dmem_resp → IDLE, strobes 0, load_data 0, resp ignored.
